// File: rtl/mult_arb_pkg.sv
// -----------------------------------------------------------------------------
// mult_arb_pkg
// Shared definitions for the multiplier arbiter: FSM state encoding and the
// operand / product widths of the external 4x4 Multiplier.
// -----------------------------------------------------------------------------
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int OPW = 4;  // operand width
    localparam int PW  = 8;  // product width

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Grants the first asserted request
// found when searching ptr, ptr+1, ... modulo NUM_REQ.
//
// Ports:
//   req        in   NUM_REQ  request vector
//   ptr        in   ID_W     index with highest priority this round
//   gnt_onehot out  NUM_REQ  one-hot grant (all zero when no request)
//   gnt_idx    out  ID_W     index of the granted request (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]    gnt_idx
);

    int              idx;
    logic [ID_W-1:0] sel;
    logic            found;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        idx        = 0;
        sel        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Wrap the search position without a modulo operator so that
            // non-power-of-two NUM_REQ values still rotate correctly.
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = ID_W'(idx);
            if (!found && req[sel]) begin
                found           = 1'b1;
                gnt_onehot[sel] = 1'b1;
                gnt_idx         = sel;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
// Time-shares one external combinational 4x4 Multiplier among NUM_REQ
// requesters. A round-robin winner's operands are registered onto mul_a/mul_b,
// the block waits SETTLE_CYC cycles, captures mul_s and returns it together
// with the requester ID on a valid/ready response channel. One operation is in
// flight at a time; the next grant rotates past the last served requester.
//
// Optional build macro: MULT_ARB_SELFCHECK_EN
//   When defined, adds output err, a sticky flag set when the captured mul_s
//   differs from mul_a*mul_b computed inside this block (cleared by rst).
//
// Ports:
//   clk        in   1          clock, rising edge
//   rst        in   1          asynchronous active-high reset
//   req_valid  in   NUM_REQ    per-requester request valid
//   req_a      in   4*NUM_REQ  operand a, requester i at [4i+3:4i]
//   req_b      in   4*NUM_REQ  operand b, same packing
//   req_ready  out  NUM_REQ    one-hot accept strobe (combinational, IDLE only)
//   mul_a      out  4          registered operand to Multiplier a
//   mul_b      out  4          registered operand to Multiplier b
//   mul_s      in   8          product from Multiplier S
//   rsp_valid  out  1          response valid
//   rsp_ready  in   1          response consumer ready
//   rsp_id     out  ID_W       requester index of the product on rsp_s
//   rsp_s      out  8          registered product
//   err        out  1          (MULT_ARB_SELFCHECK_EN only) sticky mismatch
// -----------------------------------------------------------------------------
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,   // must equal clog2(NUM_REQ)
    parameter int SETTLE_CYC = 1    // 1..15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [OPW*NUM_REQ-1:0] req_a,
    input  logic [OPW*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [OPW-1:0]         mul_a,
    output logic [OPW-1:0]         mul_b,
    input  logic [PW-1:0]          mul_s,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [PW-1:0]          rsp_s
`ifdef MULT_ARB_SELFCHECK_EN
    ,
    output logic                   err
`endif
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [3:0]          cnt;
    logic [NUM_REQ-1:0]  gnt_onehot;
    logic [ID_W-1:0]     gnt_idx;
    logic [OPW-1:0]      a_sel;
    logic [OPW-1:0]      b_sel;
    logic                xfer;
    logic [ID_W-1:0]     next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    // Operand mux driven by the one-hot grant so every slice index is constant.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_onehot[i]) begin
                a_sel = req_a[i*OPW +: OPW];
                b_sel = req_b[i*OPW +: OPW];
            end
        end
    end

    // Masked during reset so no requester sees an accept it cannot complete.
    assign req_ready = (state == IDLE && !rst) ? gnt_onehot : '0;
    assign xfer      = (state == IDLE) && (|req_valid);
    assign next_ptr  = (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_s     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        mul_a  <= a_sel;
                        mul_b  <= b_sel;
                        rsp_id <= gnt_idx;
                        cnt    <= CNT_INIT;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_s     <= mul_s;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // Rotate past the requester just served, not past rr_ptr.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULT_ARB_SELFCHECK_EN
    logic [PW-1:0] exp_s;

    assign exp_s = {4'b0, mul_a} * {4'b0, mul_b};

    // Sampled on the same edge that captures rsp_s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == MUL && cnt == 4'd0 && mul_s != exp_s) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
// Directed bench for mult_arbiter (NUM_REQ=4, SETTLE_CYC=1) with a behavioural
// 4x4 multiplier in the loop. Build with MULT_ARB_SELFCHECK_EN to cover err.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_s;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_s;
    logic        fault_en;
`ifdef MULT_ARB_SELFCHECK_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    mult_arbiter #(
        .NUM_REQ    (4),
        .ID_W       (2),
        .SETTLE_CYC (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_s     (mul_s),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s)
`ifdef MULT_ARB_SELFCHECK_EN
        ,
        .err       (err)
`endif
    );

    // Behavioural multiplier; fault_en makes it return 0 for 2*2.
    assign mul_s = (fault_en && mul_a == 4'd2 && mul_b == 4'd2) ? 8'd0
                 : {4'b0, mul_a} * {4'b0, mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transaction through requester idx with rsp_ready held high.
    task automatic xact(input int idx, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp, input string tag);
        int n;
        req_valid = 4'b0001 << idx;
        req_a = '0;
        req_b = '0;
        req_a[idx*4 +: 4] = a;
        req_b[idx*4 +: 4] = b;
        rsp_ready = 1'b1;
        #1;
        n = 0;
        while (!req_ready[idx] && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (n == 20) chk({tag, "_grant_timeout"}, 32'(req_ready), 32'(4'b0001 << idx));
        @(negedge clk);
        req_valid = '0;
        #1;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(idx));
        chk({tag, "_s"}, 32'(rsp_s), 32'(exp));
        @(negedge clk);
    endtask

    logic [7:0] rot_prod [4];

    initial begin
        rot_prod[0] = 8'd0;
        rot_prod[1] = 8'd2;
        rot_prod[2] = 8'd6;
        rot_prod[3] = 8'd12;

        rst       = 1'b1;
        fault_en  = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset state, with requests pending
        @(negedge clk); #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_b", 32'(mul_b), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_s", 32'(rsp_s), 32'd0);
`ifdef MULT_ARB_SELFCHECK_EN
        chk("rst_err", 32'(err), 32'd0);
`endif
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single request: requester 1, 3*5
        req_valid = 4'b0010;
        req_a = 16'h0030;
        req_b = 16'h0050;
        rsp_ready = 1'b0;
        #1 chk("single_grant", 32'(req_ready), 32'b0010);
        @(negedge clk); #1;
        chk("single_ready_drop", 32'(req_ready), 32'd0);
        chk("single_mul_a", 32'(mul_a), 32'd3);
        chk("single_mul_b", 32'(mul_b), 32'd5);
        chk("single_not_yet", 32'(rsp_valid), 32'd0);
        req_valid = '0;
        @(negedge clk); #1;
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_id", 32'(rsp_id), 32'd1);
        chk("single_s", 32'(rsp_s), 32'd15);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("single_done", 32'(rsp_valid), 32'd0);

        // Reset mid-MUL: request discarded (rr_ptr is 2, requester 1 wins)
        req_valid = 4'b0010;
        req_a = 16'h00A0;
        req_b = 16'h00B0;
        @(negedge clk);
        req_valid = '0;
        #1 chk("midmul_mul_a", 32'(mul_a), 32'd10);
        rst = 1'b1;
        #1;
        chk("midmul_mul_a0", 32'(mul_a), 32'd0);
        chk("midmul_mul_b0", 32'(mul_b), 32'd0);
        chk("midmul_valid0", 32'(rsp_valid), 32'd0);
        chk("midmul_id0", 32'(rsp_id), 32'd0);
        chk("midmul_ready0", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("midmul_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Rotation: all valid, a=i, b=i+1, rr_ptr back at 0
        req_valid = 4'hF;
        req_a = 16'h3210;
        req_b = 16'h4321;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 chk("rot_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            @(negedge clk); #1;
            chk("rot_busy", 32'(req_ready), 32'd0);
            @(negedge clk); #1;
            chk("rot_valid", 32'(rsp_valid), 32'd1);
            chk("rot_id", 32'(rsp_id), 32'(k % 4));
            chk("rot_s", 32'(rsp_s), 32'(rot_prod[k % 4]));
            chk("rot_resp_busy", 32'(req_ready), 32'd0);
            if (k == 4) req_valid = '0;
            @(negedge clk);
        end

        // Backpressure: rr_ptr=1, requester 3 wins with 7*9
        req_valid = 4'b1000;
        req_a = 16'h7000;
        req_b = 16'h9000;
        rsp_ready = 1'b0;
        #1 chk("bp_grant", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = 4'b1001;
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd3);
            chk("bp_s", 32'(rsp_s), 32'd63);
            chk("bp_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_next_grant", 32'(req_ready), 32'b0001);
        chk("bp_released", 32'(rsp_valid), 32'd0);
        req_valid = '0;
        @(negedge clk);

        // Max operands, then full sweep through requester 2
        xact(0, 4'd15, 4'd15, 8'd225, "max");
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                xact(2, 4'(a), 4'(b), 8'(a * b), "sweep");
            end
        end

`ifdef MULT_ARB_SELFCHECK_EN
        chk("selfchk_clean", 32'(err), 32'd0);
        fault_en = 1'b1;
        xact(1, 4'd2, 4'd2, 8'd0, "selfchk");
        #1 chk("selfchk_err", 32'(err), 32'd1);
        fault_en = 1'b0;
        xact(1, 4'd3, 4'd3, 8'd9, "selfchk_after");
        #1 chk("selfchk_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        #1 chk("selfchk_rst", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
